trackball_quad_encoder: RTL and testbench
=========================================

Name: trackball_quad_encoder

Overview:
- Converts host pointer motion (signed per-frame X/Y deltas) into 2-bit quadrature pulse trains for the trackball inputs of the LETA receiver (tb1VD/tb1VC, tb1HD/tb1HC).
- It is the transmitter end of the trackball interface: it sits between the host input path and the core's trackball pins.
- Motion is accumulated per axis and paced out as single Gray-code steps at a bounded edge rate, so the LETA counters never miss an edge.

Parameters:
- STEP_DIV, 250: clk cycles between step ticks (10 MHz / 250 = 40 kHz max edge rate per axis).
- ACC_W, 10: signed per-axis accumulator width.
- DELTA_W, 9: signed width of the input deltas.

Ports:
- clk  in  1  system clock (10 MHz core clock).
- reset  in  1  synchronous reset, active-high.
- enable  in  1  1 = run; 0 = clear both accumulators and hold the phases.
- mouse_strobe  in  1  one-cycle pulse; mouse_dx/mouse_dy are valid in this cycle.
- mouse_dx  in  DELTA_W  signed two's-complement X delta.
- mouse_dy  in  DELTA_W  signed two's-complement Y delta.
- invert_x  in  1  negate the X delta before accumulation (flip/cocktail).
- invert_y  in  1  negate the Y delta before accumulation.
- tb1HC  out  1  horizontal quadrature "clock" phase.
- tb1HD  out  1  horizontal quadrature "direction" phase.
- tb1VC  out  1  vertical quadrature "clock" phase.
- tb1VD  out  1  vertical quadrature "direction" phase.
- busy  out  1  1 while either accumulator is nonzero.

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - accumulators = 0, phase counters = 2'b00, divider = STEP_DIV-1.
  - All quadrature outputs = 0; busy = 0.
- Divider:
  - Counts down from STEP_DIV-1 to 0; tick = (count == 0); reloads STEP_DIV-1 on the cycle after 0.
  - The divider runs regardless of enable.
- Per-axis delta:
  - d = sign-extended delta when mouse_strobe = 1, else 0.
  - d is negated when the invert bit for that axis is 1.
  - Negating -2^(DELTA_W-1) yields +2^(DELTA_W-1); the extension to ACC_W makes this representable.
- Step decision on tick (per axis, independent):
  - acc > 0: s = +1 (phase increments).
  - acc < 0: s = -1 (phase decrements).
  - acc = 0: s = 0.
  - When not on tick, s = 0.
- Accumulator update:
  - acc_next = sat(acc - s + d), computed at ACC_W+1 bits.
  - sat clamps to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)]; the range is symmetric.
  - A strobe and a tick in the same cycle both take effect.
- Phase counter:
  - 2-bit p, updated p <= p + s, mod 4 (wraps 3->0 and 0->3).
- Output encoding (registered):
  - C = p[1], D = p[1]^p[0].
  - Forward (C,D) sequence: 00, 01, 11, 10, 00. Reverse is the opposite order.
  - Exactly one output bit changes per step.
  - Outputs update one cycle after the tick that changed p.
- enable = 0:
  - acc forced to 0; strobes are ignored; p is held; outputs hold their last levels.
  - Re-enabling resumes from the held phase.
- busy = (accX != 0) | (accY != 0), registered alongside the accumulators.
- Latency: a strobe in cycle n is first visible at the outputs one cycle after the first tick occurring after n.
- Throughput: one step per axis per tick; the accumulator absorbs any backlog.

Decomposition:
- Shared package, trackball_pkg:
  - Gray encoding function phase_to_cd(p).
  - ACC_MAX/ACC_MIN constants derived from ACC_W.
  - Step-direction encoding (STEP_NONE, STEP_POS, STEP_NEG).
- One sub-module: trackball_quad_axis, holding the accumulator, saturation, phase counter and output register.
  - Instantiated twice (H from dx, V from dy).
  - The top level holds the divider, the invert muxes and the busy OR.

Test Plan:
- Assert reset 3 cycles mid-operation (accX=+5) -> next cycle all outputs 0, busy 0, accX 0; first tick is STEP_DIV cycles after reset release.
- Strobe dx=+3, dy=0 -> (tb1HC,tb1HD) = 01, 11, 10 on three consecutive ticks spaced 250 cycles apart; V outputs stay 00; busy falls after the third step.
- From H phase 00, strobe dx=-2 -> (HC,HD) = 10 then 11; with invert_x=1 the same strobe gives 01 then 11.
- ACC_W=10: three strobes dx=+255 between ticks -> accX saturates at +511, not 765; exactly 511 forward steps follow; wrap 3->0 checked at each 4th step.
- Strobe dy=+1 in the same cycle as a tick while accY=+1 -> accY=+1 after that cycle; two V steps total.
- enable=0 while accX=+4 at phase 2 -> accX=0 next cycle, outputs frozen at (1,1); strobes are ignored until enable=1.

Source files
------------

// File: rtl/trackball_pkg.sv
// Shared types and helpers for the trackball quadrature transmitter.
// Phase-to-pin Gray encoding, accumulator limits and step-direction codes.
package trackball_pkg;

    localparam int ACC_W_DEFAULT = 10;
    localparam int ACC_MAX       = (1 << (ACC_W_DEFAULT - 1)) - 1;
    localparam int ACC_MIN       = -ACC_MAX;

    // Codes chosen so that adding the code to a 2-bit phase moves it by +1 / -1.
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_POS  = 2'b01,
        STEP_NEG  = 2'b11
    } step_e;

    function automatic int acc_limit(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Forward sequence of (C,D): 00, 01, 11, 10.
    function automatic logic [1:0] phase_to_cd(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

endpackage

// File: rtl/trackball_quad_axis.sv
// One trackball axis: saturating motion accumulator, 2-bit phase counter
// and registered quadrature (C,D) outputs. Steps only on divider ticks.
module trackball_quad_axis
    import trackball_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    input  logic signed [ACC_W-1:0] delta,
    output logic                    qc,
    output logic                    qd,
    output logic                    nonzero
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(acc_limit(ACC_W));
    localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic        [1:0]       phase;
    logic        [1:0]       phase_next;
    logic        [1:0]       cd;
    step_e                   step;
    logic signed [ACC_W:0]   step_ext;
    logic signed [ACC_W:0]   sum;

    always_comb begin
        step = STEP_NONE;
        if (tick && enable) begin
            if (acc[ACC_W-1]) begin
                step = STEP_NEG;
            end else if (acc != '0) begin
                step = STEP_POS;
            end
        end

        // One guard bit keeps acc - step + delta exact before clamping.
        step_ext = {{(ACC_W - 1){step[1]}}, step};
        sum      = $signed({acc[ACC_W-1], acc}) - step_ext
                 + $signed({delta[ACC_W-1], delta});

        if (sum > SAT_HI) begin
            acc_next = SAT_HI[ACC_W-1:0];
        end else if (sum < SAT_LO) begin
            acc_next = SAT_LO[ACC_W-1:0];
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
        if (!enable) begin
            acc_next = '0;
        end

        phase_next = phase + step;
        cd         = phase_to_cd(phase_next);
    end

    // Pins are registered from the next phase so they move with the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            phase <= 2'b00;
            qc    <= 1'b0;
            qd    <= 1'b0;
        end else begin
            acc   <= acc_next;
            phase <= phase_next;
            qc    <= cd[1];
            qd    <= cd[0];
        end
    end

    assign nonzero = (acc != '0);

endmodule

// File: rtl/trackball_quad_encoder.sv
// Host pointer deltas to LETA trackball quadrature pins. Holds the shared
// step divider, per-axis sign extension / inversion and the busy flag.
module trackball_quad_encoder
    import trackball_pkg::*;
#(
    parameter int STEP_DIV = 250,
    parameter int ACC_W    = ACC_W_DEFAULT,
    parameter int DELTA_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mouse_strobe,
    input  logic [DELTA_W-1:0] mouse_dx,
    input  logic [DELTA_W-1:0] mouse_dy,
    input  logic               invert_x,
    input  logic               invert_y,
    output logic               tb1HC,
    output logic               tb1HD,
    output logic               tb1VC,
    output logic               tb1VD,
    output logic               busy
);

    localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic signed [ACC_W-1:0] dx_ext;
    logic signed [ACC_W-1:0] dy_ext;
    logic signed [ACC_W-1:0] dx_in;
    logic signed [ACC_W-1:0] dy_in;
    logic                    h_nonzero;
    logic                    v_nonzero;

    // Free-running divider; it does not stop when the encoder is disabled.
    assign tick = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= DIV_LOAD;
        end else if (tick) begin
            div_cnt <= DIV_LOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // ACC_W > DELTA_W, so negating the most negative delta stays representable.
    always_comb begin
        dx_ext = '0;
        dy_ext = '0;
        if (mouse_strobe) begin
            dx_ext = {{(ACC_W - DELTA_W){mouse_dx[DELTA_W-1]}}, mouse_dx};
            dy_ext = {{(ACC_W - DELTA_W){mouse_dy[DELTA_W-1]}}, mouse_dy};
        end
        dx_in = invert_x ? -dx_ext : dx_ext;
        dy_in = invert_y ? -dy_ext : dy_ext;
    end

    trackball_quad_axis #(
        .ACC_W (ACC_W)
    ) u_axis_h (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .tick    (tick),
        .delta   (dx_in),
        .qc      (tb1HC),
        .qd      (tb1HD),
        .nonzero (h_nonzero)
    );

    trackball_quad_axis #(
        .ACC_W (ACC_W)
    ) u_axis_v (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .tick    (tick),
        .delta   (dy_in),
        .qc      (tb1VC),
        .qd      (tb1VD),
        .nonzero (v_nonzero)
    );

    assign busy = h_nonzero | v_nonzero;

endmodule

// File: tb/tb_trackball_quad_encoder.sv
// Self-checking bench for trackball_quad_encoder: expected (C,D) codes are
// queued per axis when deltas are driven and popped on each output change.
module tb_trackball_quad_encoder;

    localparam int DIV     = 20;
    localparam int ACC_W   = 10;
    localparam int DELTA_W = 9;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               mouse_strobe;
    logic [DELTA_W-1:0] mouse_dx;
    logic [DELTA_W-1:0] mouse_dy;
    logic               invert_x;
    logic               invert_y;
    logic               tb1HC;
    logic               tb1HD;
    logic               tb1VC;
    logic               tb1VD;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0] exp_h[$];
    logic [1:0] exp_v[$];
    logic [1:0] cd_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] ph_h = 2'b00;
    logic [1:0] ph_v = 2'b00;
    logic [1:0] prev_h;
    logic [1:0] prev_v;

    trackball_quad_encoder #(
        .STEP_DIV (DIV),
        .ACC_W    (ACC_W),
        .DELTA_W  (DELTA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .invert_x     (invert_x),
        .invert_y     (invert_y),
        .tb1HC        (tb1HC),
        .tb1HD        (tb1HD),
        .tb1VC        (tb1VC),
        .tb1VD        (tb1VD),
        .busy         (busy)
    );

    // ---------------- clock / reset / cycle index ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = index of the current cycle since reset release; ticks at cyc%DIV == DIV-1.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    task automatic push_h(input int n);
        for (int i = 0; i < (n < 0 ? -n : n); i++) begin
            ph_h = (n > 0) ? ph_h + 2'd1 : ph_h - 2'd1;
            exp_h.push_back(cd_tab[ph_h]);
        end
    endtask

    task automatic push_v(input int n);
        for (int i = 0; i < (n < 0 ? -n : n); i++) begin
            ph_v = (n > 0) ? ph_v + 2'd1 : ph_v - 2'd1;
            exp_v.push_back(cd_tab[ph_v]);
        end
    endtask

    // Every output change must be the next queued code, one cycle after a tick.
    always @(negedge clk) begin
        if (reset) begin
            prev_h = 2'b00;
            prev_v = 2'b00;
        end else begin
            if ({tb1HC, tb1HD} !== prev_h) begin
                if (exp_h.size() == 0) check("h_unexpected_step", {30'd0, tb1HC, tb1HD}, {30'd0, prev_h});
                else begin
                    check("h_step", {30'd0, tb1HC, tb1HD}, {30'd0, exp_h.pop_front()});
                    check("h_step_time", cyc % DIV, 0);
                end
                prev_h = {tb1HC, tb1HD};
            end
            if ({tb1VC, tb1VD} !== prev_v) begin
                if (exp_v.size() == 0) check("v_unexpected_step", {30'd0, tb1VC, tb1VD}, {30'd0, prev_v});
                else begin
                    check("v_step", {30'd0, tb1VC, tb1VD}, {30'd0, exp_v.pop_front()});
                    check("v_step_time", cyc % DIV, 0);
                end
                prev_v = {tb1VC, tb1VD};
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic strobe(input int dx, input int dy);
        mouse_strobe = 1'b1;
        mouse_dx     = DELTA_W'(dx);
        mouse_dy     = DELTA_W'(dy);
        @(negedge clk);
        mouse_strobe = 1'b0;
        mouse_dx     = '0;
        mouse_dy     = '0;
    endtask

    task automatic wait_phase(input int target);
        @(negedge clk);
        for (int i = 0; i < DIV && (cyc % DIV) != target; i++) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_h.size() != 0 || exp_v.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_done", exp_h.size() + exp_v.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset        = 1'b1;
        enable       = 1'b1;
        mouse_strobe = 1'b0;
        mouse_dx     = '0;
        mouse_dy     = '0;
        invert_x     = 1'b0;
        invert_y     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_h_out", {30'd0, tb1HC, tb1HD}, 0);
        check("rst_v_out", {30'd0, tb1VC, tb1VD}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        reset = 1'b0;

        // Move H off phase 0, then reset mid-operation with accX = +5.
        strobe(2, 0);
        push_h(2);
        wait_drain(4 * DIV);
        strobe(5, 0);
        check("acc_h_5", 32'(dut.u_axis_h.acc), 5);
        check("busy_pre_reset", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_h_out", {30'd0, tb1HC, tb1HD}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_acc_h", 32'(dut.u_axis_h.acc), 0);
        repeat (2) @(negedge clk);
        ph_h = 2'b00;
        ph_v = 2'b00;
        exp_h.delete();
        exp_v.delete();
        reset = 1'b0;

        // dx=+3 right at release: first edge at cycle DIV, then every DIV.
        strobe(3, 0);
        push_h(3);
        check("busy_after_strobe", {31'd0, busy}, 1);
        wait_drain(5 * DIV);
        check("busy_after_3", {31'd0, busy}, 0);
        check("h_out_after_3", {30'd0, tb1HC, tb1HD}, 2'b10);

        // Back to phase 0, then reverse steps, then the inverted version.
        strobe(1, 0);
        push_h(1);
        wait_drain(3 * DIV);
        strobe(-2, 0);
        push_h(-2);
        wait_drain(4 * DIV);
        strobe(2, 0);
        push_h(2);
        wait_drain(4 * DIV);
        invert_x = 1'b1;
        strobe(-2, 0);
        push_h(2);
        wait_drain(4 * DIV);
        invert_x = 1'b0;
        invert_y = 1'b1;
        strobe(-1, -1);
        push_h(-1);
        push_v(1);
        wait_drain(3 * DIV);
        invert_y = 1'b0;

        // Saturation: three +255 strobes between ticks clamp to +511.
        wait_phase(0);
        strobe(255, 0);
        strobe(255, 0);
        strobe(255, 0);
        check("acc_h_sat_pos", 32'(dut.u_axis_h.acc), 511);
        push_h(511);
        wait_drain(520 * DIV);
        check("busy_after_sat", {31'd0, busy}, 0);

        // Most negative delta inverted, then negative saturation.
        wait_phase(0);
        invert_x = 1'b1;
        strobe(-256, 0);
        check("acc_h_neg256_inv", 32'(dut.u_axis_h.acc), 256);
        invert_x = 1'b0;
        strobe(-256, 0);
        check("acc_h_back_zero", 32'(dut.u_axis_h.acc), 0);
        strobe(-256, 0);
        strobe(-256, 0);
        check("acc_h_sat_neg", 32'(dut.u_axis_h.acc), -511);
        push_h(-511);
        wait_drain(520 * DIV);
        check("busy_after_negsat", {31'd0, busy}, 0);

        // Strobe on the same cycle as a tick: both take effect.
        wait_phase(0);
        strobe(0, 2);
        push_v(2);
        wait_phase(DIV - 1);
        wait_phase(DIV - 1);
        check("acc_v_pre_tick", 32'(dut.u_axis_v.acc), 1);
        strobe(0, 1);
        push_v(1);
        check("acc_v_same_cycle", 32'(dut.u_axis_v.acc), 1);
        wait_drain(4 * DIV);

        // Disable with accX = +4 at phase 2: acc clears, pins freeze at (1,1).
        k = int'((2'd2 - ph_h) & 2'd3);
        wait_phase(0);
        strobe(k + 4, 0);
        push_h(k);
        wait_drain(6 * DIV);
        check("acc_h_pre_disable", 32'(dut.u_axis_h.acc), 4);
        check("h_out_phase2", {30'd0, tb1HC, tb1HD}, 2'b11);
        enable = 1'b0;
        @(negedge clk);
        check("dis_acc_h", 32'(dut.u_axis_h.acc), 0);
        check("dis_busy", {31'd0, busy}, 0);
        strobe(3, 3);
        repeat (3 * DIV) @(negedge clk);
        check("dis_h_frozen", {30'd0, tb1HC, tb1HD}, 2'b11);
        check("dis_acc_ignored", 32'(dut.u_axis_h.acc), 0);
        check("dis_busy_held", {31'd0, busy}, 0);
        enable = 1'b1;
        strobe(1, 0);
        push_h(1);
        wait_drain(3 * DIV);
        check("reen_h_out", {30'd0, tb1HC, tb1HD}, 2'b10);
        check("final_busy", {31'd0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop so the run always ends with a summary.
    initial begin
        #(3_000_000);
        check("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
